la_capture_dump: RTL and testbench
==================================

// Module: la_capture_dump
// PURPOSE
//  Downstream sink of the logic-analyser sampling stage. Stores the sampled byte stream
//  (wr_data/wr_en/wr_addr) into an internal sample RAM and tracks the highest written address.
//  On dump_req it freezes the RAM and streams a 4-byte header plus all captured bytes
//  over a 115200-baud 8N1 UART to the host.
// PARAMETERS
//  ADDR_W   17          sample RAM address width; depth = 2**ADDR_W bytes
//  CLK_HZ   50_000_000  clk_50M frequency
//  BAUD     115200      UART bit rate; BIT_DIV = CLK_HZ/BAUD (434 at defaults)
// PORTS
//  clk_50M   in   1       system clock, single clock domain
//  rst_n     in   1       asynchronous active-low reset
//  wr_data   in   8       sample byte from the sampling stage
//  wr_en     in   1       write strobe, one sample per high cycle
//  wr_addr   in   ADDR_W  sample RAM write address
//  dump_req  in   1       single-cycle pulse: start dump (ignored while busy)
//  uart_tx   out  1       serial output, idles high
//  busy      out  1       high from dump acceptance until the last stop bit ends
//  dump_done out  1       one-cycle pulse in the cycle after the last stop bit
//  wr_drop   out  1       sticky: a write arrived while busy; cleared by the next accepted dump_req
// BEHAVIOUR
//  Reset: uart_tx=1, busy=0, dump_done=0, wr_drop=0, max_addr=0, any_wr=0, FSM=IDLE.
//   RAM contents are not reset.
//  Capture (busy=0): wr_en=1 -> ram[wr_addr]<=wr_data; any_wr<=1;
//   max_addr<=max(max_addr,wr_addr).
//  Capture (busy=1): write discarded, RAM unchanged, wr_drop<=1.
//  len (24 bit, zero-extended) = any_wr ? max_addr+1 : 0; latched at dump_req acceptance.
//   Unwritten holes below max_addr are dumped with their stale contents.
//  Stream: 0xA5, len[23:16], len[15:8], len[7:0], then ram[0..len-1] in address order.
//  FSM:
//   IDLE -dump_req-> HDR (busy<=1)
//   HDR  sends 4 header bytes; after the 4th: len==0 -> FIN, else -> RD
//   RD   issues RAM read (1-cycle sync read latency) -> LD
//   LD   loads byte into TX -> TXW
//   TXW  waits for byte-done; rd_addr==len-1 -> FIN, else rd_addr++ -> RD
//   FIN  busy<=0, dump_done<=1 for 1 cycle, any_wr<=0, max_addr<=0 -> IDLE
//  UART frame: start bit 0, 8 data bits LSB first, stop bit 1. Each bit lasts exactly BIT_DIV
//   cycles. Between bytes the only gap is the RD/LD overhead of at most 3 cycles of idle-high.
//  dump_req while busy: ignored, no queueing. dump_req and wr_en in the same IDLE cycle:
//   the write is committed and included in len.
//  Read addressing: rd_addr is ADDR_W bits. len=2**ADDR_W is legal and ends at address
//   all-ones with no wrap.
//  Reset mid-dump: uart_tx forced high asynchronously and the FSM returns to IDLE.
//   The host detects the truncation by length mismatch.
// STRUCTURE
//  Package la_pkg: LA_HDR_BYTE=8'hA5, state enum type, function bit_div(CLK_HZ,BAUD).
//  Sub-module la_uart_tx:
//   ports clk_50M, rst_n, start, data[7:0], tx, done (1-cycle pulse at end of stop bit).
//   Contains the baud counter and 10-bit shift register.
//  Top level holds the inferred simple dual-port RAM (2**ADDR_W x 8), address tracking
//   and the dump FSM.
// TESTING
//  1 Reset released, idle 2000 cycles -> uart_tx=1, busy=0, dump_done never pulses, wr_drop=0.
//  2 Write 11,22,33,44 at addr 0..3, then dump_req -> UART decodes A5 00 00 04 11 22 33 44;
//    every bit is 434 cycles; dump_done is a single pulse one cycle after the last stop bit.
//  3 dump_req with no writes since reset -> A5 00 00 00, then dump_done; busy is high only
//    during those 4 frames.
//  4 During test 2, wr_en=1 with addr 0 and data FF while busy -> wr_drop=1. A second dump
//    still shows 11 at addr 0; the second dump_req clears wr_drop.
//  5 Single write data 5A at addr 0x1FFFF -> header A5 02 00 00; the final byte is 5A;
//    rd_addr does not wrap past 0x1FFFF.
//  6 Assert rst_n=0 mid-frame during byte 6 -> uart_tx=1 immediately, busy=0. A new
//    dump_req after release sends a fresh A5 00 00 00.

Source files
------------

// File: rtl/la_capture_dump_pkg.sv
// Shared constants, FSM state type and baud divider helper for the logic-analyser capture/dump block.
package la_pkg;

    localparam logic [7:0]  LA_HDR_BYTE = 8'hA5;
    localparam int unsigned LEN_W       = 24;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_RD,
        ST_LD,
        ST_TXW,
        ST_FIN
    } la_state_e;

    function automatic int unsigned bit_div(input int unsigned clk_hz, input int unsigned baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/la_capture_dump_if.sv
// Sample-write, dump-control and status signals between the sampling stage/host side and the dump block.
interface la_capture_dump_if #(
    parameter int unsigned ADDR_W = 17
);
    logic [7:0]        wr_data;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic              dump_req;
    logic              uart_tx;
    logic              busy;
    logic              dump_done;
    logic              wr_drop;

    modport master (
        output wr_data, wr_en, wr_addr, dump_req,
        input  uart_tx, busy, dump_done, wr_drop
    );

    modport slave (
        input  wr_data, wr_en, wr_addr, dump_req,
        output uart_tx, busy, dump_done, wr_drop
    );
endinterface

// File: rtl/la_capture_dump_uart_tx.sv
// 8N1 UART transmitter; done is high during the last cycle of the stop bit.
module la_uart_tx #(
    parameter int unsigned BIT_DIV = 434
) (
    input  logic       clk_50M,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       done
);
    localparam int unsigned          CNT_W    = $clog2(BIT_DIV);
    localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(BIT_DIV - 1);
    localparam logic [CNT_W-1:0]     CNT_PRE  = CNT_W'(BIT_DIV - 2);

    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       r_bit;
    logic [9:0]       r_shift;
    logic             r_active;
    logic             r_tx;
    logic             r_done;

    // Reset drives the line idle-high immediately, truncating any frame in flight.
    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_bit    <= '0;
            r_shift  <= '1;
            r_active <= 1'b0;
            r_tx     <= 1'b1;
            r_done   <= 1'b0;
        end else begin
            r_done <= r_active && (r_bit == 4'd9) && (r_cnt == CNT_PRE);
            if (!r_active) begin
                if (start) begin
                    r_shift  <= {1'b1, data, 1'b0};
                    r_tx     <= 1'b0;
                    r_cnt    <= '0;
                    r_bit    <= '0;
                    r_active <= 1'b1;
                end
            end else if (r_cnt == CNT_LAST) begin
                r_cnt <= '0;
                if (r_bit == 4'd9) begin
                    r_active <= 1'b0;
                    r_tx     <= 1'b1;
                end else begin
                    r_bit   <= r_bit + 4'd1;
                    r_tx    <= r_shift[1];
                    r_shift <= {1'b1, r_shift[9:1]};
                end
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign tx   = r_tx;
    assign done = r_done;

endmodule

// File: rtl/la_capture_dump.sv
// Sample RAM with max-address tracking; on dump_req streams A5 + 24-bit length + captured bytes over UART.
module la_capture_dump
    import la_pkg::*;
#(
    parameter int unsigned ADDR_W = 17,
    parameter int unsigned CLK_HZ = 50_000_000,
    parameter int unsigned BAUD   = 115200
) (
    input logic             clk_50M,
    input logic             rst_n,
    la_capture_dump_if.slave bus
);
    localparam int unsigned BIT_DIV = bit_div(CLK_HZ, BAUD);
    localparam int unsigned DEPTH   = 2 ** ADDR_W;

    logic [7:0]        r_ram [DEPTH];
    logic [7:0]        r_rd_data;
    logic [ADDR_W-1:0] r_rd_addr;
    logic [ADDR_W-1:0] r_max_addr;
    logic              r_any_wr;
    logic [LEN_W-1:0]  r_len;
    la_state_e         r_state;
    logic [1:0]        r_hdr_idx;
    logic              r_busy;
    logic              r_dump_done;
    logic              r_wr_drop;
    logic              r_tx_start;
    logic [7:0]        r_tx_data;

    logic              w_tx;
    logic              w_tx_done;
    logic              w_accept;
    logic              w_wr;
    logic [ADDR_W-1:0] w_max_nxt;
    logic              w_any_nxt;
    logic [LEN_W-1:0]  w_len_nxt;
    logic              w_last_rd;
    logic              w_finish;
    logic [7:0]        w_hdr_next;

    assign w_accept  = bus.dump_req && !r_busy;
    assign w_wr      = bus.wr_en && !r_busy;
    assign w_max_nxt = (w_wr && (bus.wr_addr > r_max_addr)) ? bus.wr_addr : r_max_addr;
    assign w_any_nxt = r_any_wr | w_wr;
    // A write in the accepting cycle is already counted in the length.
    assign w_len_nxt = w_any_nxt ? (LEN_W'(w_max_nxt) + LEN_W'(1)) : '0;
    assign w_last_rd = (LEN_W'(r_rd_addr) == (r_len - LEN_W'(1)));
    assign w_finish  = w_tx_done &&
                       (((r_state == ST_HDR) && (r_hdr_idx == 2'd3) && (r_len == '0)) ||
                        ((r_state == ST_TXW) && w_last_rd));

    always_comb begin
        w_hdr_next = r_len[7:0];
        case (r_hdr_idx)
            2'd0:    w_hdr_next = r_len[23:16];
            2'd1:    w_hdr_next = r_len[15:8];
            default: w_hdr_next = r_len[7:0];
        endcase
    end

    always_ff @(posedge clk_50M) begin
        if (w_wr) r_ram[bus.wr_addr] <= bus.wr_data;
        if (r_state == ST_RD) r_rd_data <= r_ram[r_rd_addr];
    end

    // Capture bookkeeping; cleared on the same edge that ends the dump.
    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            r_any_wr   <= 1'b0;
            r_max_addr <= '0;
            r_wr_drop  <= 1'b0;
        end else begin
            if (w_finish) begin
                r_any_wr   <= 1'b0;
                r_max_addr <= '0;
            end else begin
                r_any_wr   <= w_any_nxt;
                r_max_addr <= w_max_nxt;
            end
            if (w_accept) r_wr_drop <= 1'b0;
            else if (bus.wr_en && r_busy) r_wr_drop <= 1'b1;
        end
    end

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_busy      <= 1'b0;
            r_dump_done <= 1'b0;
            r_tx_start  <= 1'b0;
            r_tx_data   <= '0;
            r_hdr_idx   <= '0;
            r_rd_addr   <= '0;
            r_len       <= '0;
        end else begin
            r_tx_start  <= 1'b0;
            r_dump_done <= 1'b0;
            if (w_finish) begin
                r_busy      <= 1'b0;
                r_dump_done <= 1'b1;
                r_state     <= ST_FIN;
            end else begin
                case (r_state)
                    ST_IDLE, ST_FIN: begin
                        r_state <= ST_IDLE;
                        if (w_accept) begin
                            r_state    <= ST_HDR;
                            r_busy     <= 1'b1;
                            r_len      <= w_len_nxt;
                            r_hdr_idx  <= '0;
                            r_rd_addr  <= '0;
                            r_tx_start <= 1'b1;
                            r_tx_data  <= LA_HDR_BYTE;
                        end
                    end
                    ST_HDR: begin
                        if (w_tx_done) begin
                            if (r_hdr_idx == 2'd3) begin
                                r_state <= ST_RD;
                            end else begin
                                r_hdr_idx  <= r_hdr_idx + 2'd1;
                                r_tx_start <= 1'b1;
                                r_tx_data  <= w_hdr_next;
                            end
                        end
                    end
                    ST_RD:   r_state <= ST_LD;
                    ST_LD: begin
                        r_tx_data  <= r_rd_data;
                        r_tx_start <= 1'b1;
                        r_state    <= ST_TXW;
                    end
                    ST_TXW: begin
                        if (w_tx_done) begin
                            r_rd_addr <= r_rd_addr + ADDR_W'(1);
                            r_state   <= ST_RD;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    la_uart_tx #(
        .BIT_DIV (BIT_DIV)
    ) u_tx (
        .clk_50M (clk_50M),
        .rst_n   (rst_n),
        .start   (r_tx_start),
        .data    (r_tx_data),
        .tx      (w_tx),
        .done    (w_tx_done)
    );

    assign bus.uart_tx   = w_tx;
    assign bus.busy      = r_busy;
    assign bus.dump_done = r_dump_done;
    assign bus.wr_drop   = r_wr_drop;

endmodule

// File: tb/tb_la_capture_dump.sv
// Directed bench: scaled-down RAM and baud divider, UART frames decoded and compared to hand-computed bytes.
module tb_la_capture_dump;

    localparam int unsigned ADDR_W   = 3;
    localparam int unsigned CLK_HZ   = 1_000_000;
    localparam int unsigned BAUD     = 100_000;
    localparam int unsigned D        = 10;
    localparam int unsigned START_TO = 50;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;
    int   exp_q [$];

    la_capture_dump_if #(.ADDR_W(ADDR_W)) bus ();

    la_capture_dump #(
        .ADDR_W (ADDR_W),
        .CLK_HZ (CLK_HZ),
        .BAUD   (BAUD)
    ) dut (
        .clk_50M (clk),
        .rst_n   (rst_n),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic write_byte(input logic [ADDR_W-1:0] a, input logic [7:0] d);
        bus.wr_en   = 1'b1;
        bus.wr_addr = a;
        bus.wr_data = d;
        @(negedge clk);
        bus.wr_en   = 1'b0;
    endtask

    task automatic pulse_dump();
        bus.dump_req = 1'b1;
        @(negedge clk);
        bus.dump_req = 1'b0;
    endtask

    task automatic wait_start(output bit tout);
        int w;
        w = 0;
        while ((bus.uart_tx !== 1'b0) && (w < int'(START_TO))) begin
            @(negedge clk);
            w++;
        end
        tout = (bus.uart_tx !== 1'b0);
    endtask

    // Samples every cycle of the frame; each cycle must match its bit's mid-point value.
    task automatic recv_byte(output logic [7:0] b, output int terr, output bit tout);
        logic s [10*D];
        terr = 0;
        b    = '0;
        wait_start(tout);
        if (!tout) begin
            for (int c = 0; c < int'(10*D); c++) begin
                if (c > 0) @(negedge clk);
                s[c] = bus.uart_tx;
            end
            for (int c = 0; c < int'(10*D); c++)
                if (s[c] !== s[(c/int'(D))*int'(D) + int'(D/2)]) terr++;
            if (s[D/2] !== 1'b0) terr++;
            if (s[9*D + D/2] !== 1'b1) terr++;
            for (int j = 0; j < 8; j++) b[j] = s[(j+1)*int'(D) + int'(D/2)];
        end
    endtask

    task automatic run_dump(input string tag);
        logic [7:0] b;
        int         terr;
        int         tsum;
        bit         tout;
        tsum = 0;
        check_val({tag, "_busy_hi"}, 32'(bus.busy), 32'd1);
        for (int i = 0; i < exp_q.size(); i++) begin
            recv_byte(b, terr, tout);
            check_val($sformatf("%s_timeout%0d", tag, i), 32'(tout), 32'd0);
            if (tout) break;
            tsum += terr;
            if (exp_q[i] >= 0)
                check_val($sformatf("%s_byte%0d", tag, i), 32'(b), 32'(exp_q[i]));
        end
        check_val({tag, "_bit_timing"}, 32'(tsum), 32'd0);
        @(negedge clk);
        check_val({tag, "_done_pulse"}, 32'(bus.dump_done), 32'd1);
        check_val({tag, "_busy_lo"}, 32'(bus.busy), 32'd0);
        @(negedge clk);
        check_val({tag, "_done_single"}, 32'(bus.dump_done), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got sim time limit expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int         dd_cnt;
        int         tx_bad;
        logic [7:0] b;
        int         terr;
        bit         tout;

        n_checks     = 0;
        n_fail       = 0;
        rst_n        = 1'b0;
        bus.wr_en    = 1'b0;
        bus.wr_addr  = '0;
        bus.wr_data  = '0;
        bus.dump_req = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;

        // Reset values and long idle
        check_val("rst_tx", 32'(bus.uart_tx), 32'd1);
        check_val("rst_busy", 32'(bus.busy), 32'd0);
        check_val("rst_drop", 32'(bus.wr_drop), 32'd0);
        dd_cnt = 0;
        tx_bad = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (bus.dump_done !== 1'b0) dd_cnt++;
            if (bus.uart_tx !== 1'b1) tx_bad++;
        end
        check_val("idle_done_pulses", 32'(dd_cnt), 32'd0);
        check_val("idle_tx_low", 32'(tx_bad), 32'd0);
        check_val("idle_busy", 32'(bus.busy), 32'd0);

        // Empty dump: header only
        pulse_dump();
        exp_q = '{'hA5, 'h00, 'h00, 'h00};
        run_dump("empty");

        // Four bytes, plus a write that must be dropped while busy
        write_byte(3'd0, 8'h11);
        write_byte(3'd1, 8'h22);
        write_byte(3'd2, 8'h33);
        write_byte(3'd3, 8'h44);
        check_val("pre_dump_busy", 32'(bus.busy), 32'd0);
        pulse_dump();
        write_byte(3'd0, 8'hFF);
        check_val("drop_set", 32'(bus.wr_drop), 32'd1);
        exp_q = '{'hA5, 'h00, 'h00, 'h04, 'h11, 'h22, 'h33, 'h44};
        run_dump("four");
        check_val("drop_sticky", 32'(bus.wr_drop), 32'd1);

        // Second dump still sees 11 at address 0; acceptance clears wr_drop
        write_byte(3'd1, 8'h66);
        pulse_dump();
        check_val("drop_clear", 32'(bus.wr_drop), 32'd0);
        exp_q = '{'hA5, 'h00, 'h00, 'h02, 'h11, 'h66};
        run_dump("second");

        // Top address only: full-depth length, stale bytes 4..6 not predicted
        write_byte(3'd7, 8'h5A);
        pulse_dump();
        exp_q = '{'hA5, 'h00, 'h00, 'h08, 'h11, 'h66, 'h33, 'h44, -1, -1, -1, 'h5A};
        run_dump("top");

        // Reset during the start bit of byte 6
        write_byte(3'd0, 8'hAA);
        write_byte(3'd1, 8'hBB);
        pulse_dump();
        exp_q = '{'hA5, 'h00, 'h00, 'h02, 'hAA};
        for (int i = 0; i < exp_q.size(); i++) begin
            recv_byte(b, terr, tout);
            check_val($sformatf("trunc_timeout%0d", i), 32'(tout), 32'd0);
            if (tout) break;
            check_val($sformatf("trunc_byte%0d", i), 32'(b), 32'(exp_q[i]));
        end
        wait_start(tout);
        check_val("trunc_b6_timeout", 32'(tout), 32'd0);
        repeat (3) @(negedge clk);
        check_val("trunc_tx_pre", 32'(bus.uart_tx), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("trunc_tx_rst", 32'(bus.uart_tx), 32'd1);
        check_val("trunc_busy_rst", 32'(bus.busy), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_val("trunc_tx_idle", 32'(bus.uart_tx), 32'd1);
        pulse_dump();
        exp_q = '{'hA5, 'h00, 'h00, 'h00};
        run_dump("after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
